// File: rtl/sync_ram_pkg.sv
// Shared types and default sizes for the sync_ram simple-dual-port RAM.
package sync_ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 8;

endpackage : sync_ram_pkg

// File: rtl/sync_ram.sv
// Simple-dual-port synchronous RAM with a post-reset clear engine and write-first forwarding.
// Optional macro SYNC_RAM_OUTREG_EN adds a second output register (read latency 2).
module sync_ram
   import sync_ram_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] data_in,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   output logic              busy
);

   localparam int DEPTH = 2 ** ADDR_W;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_clr_ptr;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_clr_last;
   logic              w_ready;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;
   logic              w_rd_fire;
   logic              w_collide;

   logic [DATA_W-1:0] r_rd_data;
   logic              r_rd_valid;

   assign w_clr_last = &r_clr_ptr;
   assign w_ready    = (r_state == READY);
   assign busy       = (r_state == CLEAR);

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_state <= CLEAR;
      else     r_state <= w_state_nxt;
   end

   // NOTE: the default assignment first keeps this combinational block free of latches.
   always_comb begin
      w_state_nxt = r_state;
      if (r_state == CLEAR && w_clr_last) w_state_nxt = READY;
   end

   always_ff @(posedge clk) begin
      if (rst)                  r_clr_ptr <= '0;
      else if (r_state == CLEAR) r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
   end

   // Clear engine owns the write port while busy; user requests are dropped, not queued.
   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_addr  = waddr;
      w_mem_wdata = data_in;
      if (!rst) begin
         if (r_state == CLEAR) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_clr_ptr;
            w_mem_wdata = '0;
         end else begin
            w_mem_we = we;
         end
      end
   end

   // NOTE: the array has no reset branch so it maps onto block RAM; the clear engine zeroes it instead.
   always_ff @(posedge clk) begin
      if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
   end

   assign w_rd_fire = w_ready && re;
   assign w_collide = we && (waddr == raddr);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else if (w_rd_fire) begin
         r_rd_data  <= w_collide ? data_in : r_mem[raddr];
         r_rd_valid <= 1'b1;
      end else begin
         r_rd_valid <= 1'b0;
      end
   end

`ifdef SYNC_RAM_OUTREG_EN
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_data  <= r_rd_data;
         r_out_valid <= r_rd_valid;
      end
   end

   assign data_out = r_out_data;
   assign rd_valid = r_out_valid;
`else
   assign data_out = r_rd_data;
   assign rd_valid = r_rd_valid;
`endif

endmodule : sync_ram

// File: tb/tb_sync_ram.sv
// Directed self-checking bench for sync_ram (8x256 default); honours SYNC_RAM_OUTREG_EN latency.
module tb_sync_ram;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 2 ** ADDR_W;
`ifdef SYNC_RAM_OUTREG_EN
   localparam int RD_LAT = 2;
`else
   localparam int RD_LAT = 1;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] data_in;
   logic              re;
   logic [ADDR_W-1:0] raddr;
   logic [DATA_W-1:0] data_out;
   logic              rd_valid;
   logic              busy;

   int n_vec = 0;
   int n_err = 0;

   sync_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .waddr    (waddr),
      .data_in  (data_in),
      .re       (re),
      .raddr    (raddr),
      .data_out (data_out),
      .rd_valid (rd_valid),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      we = 1'b1; waddr = a; data_in = d;
      tick();
      we = 1'b0;
   endtask

   // Issue one read and wait until its result reaches the outputs.
   task automatic read_check(input string tag, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] exp);
      re = 1'b1; raddr = a;
      tick();
      re = 1'b0;
      repeat (RD_LAT - 1) tick();
      check({tag, "_data"}, 32'(data_out), 32'(exp));
      check({tag, "_vld"}, 32'(rd_valid), 32'd1);
   endtask

   // Counts posedges until busy drops; also reports any rd_valid seen meanwhile.
   task automatic count_busy(output int n, output int vld_seen);
      n = 0; vld_seen = 0;
      while (busy === 1'b1 && n < 1000) begin
         tick();
         n++;
         if (busy === 1'b1 && rd_valid !== 1'b0) vld_seen++;
      end
   endtask

   initial begin
      int n_busy;
      int n_vld;
      int zero_bad;

      rst = 1'b1; we = 1'b0; re = 1'b0;
      waddr = '0; raddr = '0; data_in = '0;

      // Reset state
      tick();
      rst = 1'b0;
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_data", 32'(data_out), 32'd0);
      check("rst_vld", 32'(rd_valid), 32'd0);

      // Clear duration, with write/read requests held throughout (must be dropped)
      we = 1'b1; waddr = 8'h05; data_in = 8'hFF;
      re = 1'b1; raddr = 8'h05;
      count_busy(n_busy, n_vld);
      we = 1'b0; re = 1'b0;
      check("clr_cycles", 32'(n_busy), 32'd256);
      check("clr_no_vld", 32'(n_vld), 32'd0);
      check("ready_busy", 32'(busy), 32'd0);

      // Dropped write during CLEAR must leave 0x05 at zero
      read_check("drop_05", 8'h05, 8'h00);

      // Every word cleared
      zero_bad = 0;
      for (int a = 0; a < DEPTH; a++) begin
         re = 1'b1; raddr = ADDR_W'(a);
         tick();
         re = 1'b0;
         repeat (RD_LAT - 1) tick();
         if (data_out !== 8'h00 || rd_valid !== 1'b1) zero_bad++;
      end
      check("clr_all_zero", 32'(zero_bad), 32'd0);

      // Basic write then read
      tick();
      write(8'h10, 8'hA5);
      check("idle_vld", 32'(rd_valid), 32'd0);
      read_check("rw_10", 8'h10, 8'hA5);
      tick();
      check("hold_data", 32'(data_out), 32'h0A5);
      check("hold_vld", 32'(rd_valid), 32'd0);

      // Collision: same-address write and read forward the new data
      write(8'h20, 8'h11);
      we = 1'b1; waddr = 8'h20; data_in = 8'h77;
      read_check("coll_20", 8'h20, 8'h77);
      read_check("coll_after", 8'h20, 8'h77);

      // Different-address write must not forward
      we = 1'b1; waddr = 8'h21; data_in = 8'h33;
      read_check("nocoll_20", 8'h20, 8'h77);
      read_check("nocoll_21", 8'h21, 8'h33);

      // Back-to-back reads at 0..3 holding 1..4
      for (int i = 0; i < 4; i++) write(ADDR_W'(i), DATA_W'(i + 1));
      for (int i = 0; i < 4 + RD_LAT - 1; i++) begin
         if (i < 4) begin
            re = 1'b1; raddr = ADDR_W'(i);
         end else begin
            re = 1'b0;
         end
         tick();
         if (i >= RD_LAT - 1) begin
            check($sformatf("b2b_data%0d", i - RD_LAT + 1), 32'(data_out), 32'(i - RD_LAT + 2));
            check($sformatf("b2b_vld%0d", i - RD_LAT + 1), 32'(rd_valid), 32'd1);
         end
      end
      re = 1'b0;
      tick();
      check("b2b_vld_drop", 32'(rd_valid), 32'd0);

      // Reset mid-clear at clr_ptr == 100
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (100) tick();
      check("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_data", 32'(data_out), 32'd0);
      check("mid_rst_vld", 32'(rd_valid), 32'd0);
      count_busy(n_busy, n_vld);
      check("mid_clr_cycles", 32'(n_busy), 32'd256);
      read_check("mid_10", 8'h10, 8'h00);
      read_check("mid_21", 8'h21, 8'h00);
      read_check("mid_03", 8'h03, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_sync_ram
